// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control FSM of the multicycle 16-bit processor. Walks each instruction
// through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and drives every
// datapath enable and mux select. Also produces the destination register
// address and write strobe consumed by the register-file write decoder.
//
// Instruction fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2,
// [2:0] funct. The immediate (instr[5:0]) is extended in the datapath.
//
// Ports
//   i_clk          in   1   system clock, rising edge
//   i_rst          in   1   asynchronous, active-high reset
//   i_instr        in   16  IR contents, valid from DECODE onward
//   i_mem_ready    in   1   memory access completes in this cycle
//   i_alu_zero     in   1   ALU result == 0
//   o_pc_write     out  1   PC load enable
//   o_pc_src       out  2   00 = PC+2, 01 = ALUOut (branch), 10 = jump target
//   o_ir_write     out  1   IR load enable
//   o_iord         out  1   memory address select: 0 = PC, 1 = ALUOut
//   o_mem_read     out  1   memory read request
//   o_mem_write    out  1   memory write request
//   o_alu_src_a    out  1   0 = PC, 1 = rs1
//   o_alu_src_b    out  2   00 = rs2, 01 = 2, 10 = imm, 11 = imm<<1
//   o_alu_op       out  3   000 = ADD, 001 = SUB, others = funct pass-through
//   o_reg_write    out  1   register-file write strobe
//   o_rd_addr      out  3   destination register (instr[11:9])
//   o_mem_to_reg   out  1   write-back select: 0 = ALUOut, 1 = MDR
//   o_halted       out  1   HALT reached (sticky until reset)
//   o_illegal      out  1   undefined opcode trapped (sticky until reset)
//   o_state        out  4   current state, debug only
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_instr,
   input  logic        i_mem_ready,
   input  logic        i_alu_zero,
   output logic        o_pc_write,
   output logic [1:0]  o_pc_src,
   output logic        o_ir_write,
   output logic        o_iord,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_alu_src_a,
   output logic [1:0]  o_alu_src_b,
   output logic [2:0]  o_alu_op,
   output logic        o_reg_write,
   output logic [2:0]  o_rd_addr,
   output logic        o_mem_to_reg,
   output logic        o_halted,
   output logic        o_illegal,
   output logic [3:0]  o_state
);

   localparam logic [3:0] OP_R    = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BEQ  = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   // Encodings 4'hE and 4'hF are unused and fall back to RESET.
   typedef enum logic [3:0] {
      S_RESET    = 4'h0,
      S_FETCH    = 4'h1,
      S_DECODE   = 4'h2,
      S_EXEC_R   = 4'h3,
      S_EXEC_I   = 4'h4,
      S_MEM_ADDR = 4'h5,
      S_MEM_RD   = 4'h6,
      S_MEM_WR   = 4'h7,
      S_WB_ALU   = 4'h8,
      S_WB_MEM   = 4'h9,
      S_BRANCH   = 4'hA,
      S_JUMP     = 4'hB,
      S_HALT     = 4'hC,
      S_ILLEGAL  = 4'hD
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  w_opcode;
   logic [2:0]  w_rd;
   logic [2:0]  w_funct;
   logic        w_reg_write;
   logic        w_unused;

   assign w_opcode = i_instr[15:12];
   assign w_rd     = i_instr[11:9];
   assign w_funct  = i_instr[2:0];
   // Register and immediate fields are consumed by the datapath, not here.
   assign w_unused = ^i_instr[8:3];

   assign o_state = r_state;

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = S_RESET;
      case (r_state)
         S_RESET:    w_next_state = S_FETCH;
         S_FETCH:    w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (w_opcode)
               OP_R:          w_next_state = S_EXEC_R;
               OP_ADDI:       w_next_state = S_EXEC_I;
               OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
               OP_BEQ:        w_next_state = S_BRANCH;
               OP_JMP:        w_next_state = S_JUMP;
               OP_HALT:       w_next_state = S_HALT;
               default:       w_next_state = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:   w_next_state = S_WB_ALU;
         S_EXEC_I:   w_next_state = S_WB_ALU;
         // Only LW and SW can reach MEM_ADDR, so bit 0 of the opcode picks.
         S_MEM_ADDR: w_next_state = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   w_next_state = i_mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   w_next_state = i_mem_ready ? S_FETCH : S_MEM_WR;
         S_WB_ALU:   w_next_state = S_FETCH;
         S_WB_MEM:   w_next_state = S_FETCH;
         S_BRANCH:   w_next_state = S_FETCH;
         S_JUMP:     w_next_state = S_FETCH;
         S_HALT:     w_next_state = S_HALT;
         S_ILLEGAL:  w_next_state = S_ILLEGAL;
         default:    w_next_state = S_RESET;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      o_pc_write   = 1'b0;
      o_pc_src     = 2'b00;
      o_ir_write   = 1'b0;
      o_iord       = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_alu_op     = ALU_ADD;
      o_mem_to_reg = 1'b0;
      o_halted     = 1'b0;
      o_illegal    = 1'b0;
      o_rd_addr    = 3'b000;
      w_reg_write  = 1'b0;

      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            // IR and PC+2 are captured on the cycle memory delivers the word.
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut speculatively.
            o_alu_src_b = 2'b11;
         end
         S_EXEC_R: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b00;
            o_alu_op    = w_funct;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         S_MEM_WR: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         S_WB_ALU: begin
            w_reg_write = 1'b1;
         end
         S_WB_MEM: begin
            w_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = 2'b00;
            o_alu_op    = ALU_SUB;
            o_pc_src    = 2'b01;
            o_pc_write  = i_alu_zero;
         end
         S_JUMP: begin
            o_pc_src   = 2'b10;
            o_pc_write = 1'b1;
         end
         S_HALT:    o_halted  = 1'b1;
         S_ILLEGAL: o_illegal = 1'b1;
         default: ;
      endcase

      if (r_state != S_RESET) begin
         o_rd_addr = w_rd;
      end
      // x0 is hard-wired zero: never strobe a write to it.
      o_reg_write = w_reg_write & (w_rd != 3'b000);
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

   // Architectural phases of an instruction, used only by the reference model.
   typedef enum {
      PH_RESET, PH_FETCH, PH_DECODE, PH_EXEC_R, PH_EXEC_I, PH_MEM_ADDR,
      PH_MEM_RD, PH_MEM_WR, PH_WB_ALU, PH_WB_MEM, PH_BRANCH, PH_JUMP,
      PH_HALT, PH_ILLEGAL
   } phase_t;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_write;
      logic [2:0] rd_addr;
      logic       mem_to_reg;
      logic       halted;
      logic       illegal;
   } ctrl_t;

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        ir_write;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_op;
   logic        reg_write;
   logic [2:0]  rd_addr;
   logic        mem_to_reg;
   logic        halted;
   logic        illegal;
   logic [3:0]  state;

   ctrl_t act;
   int    n_asserts = 0;
   int    n_fail    = 0;

   assign act = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                 alu_src_a, alu_src_b, alu_op, reg_write, rd_addr,
                 mem_to_reg, halted, illegal};

   multicycle_ctrl_fsm dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_instr      (instr),
      .i_mem_ready  (mem_ready),
      .i_alu_zero   (alu_zero),
      .o_pc_write   (pc_write),
      .o_pc_src     (pc_src),
      .o_ir_write   (ir_write),
      .o_iord       (iord),
      .o_mem_read   (mem_read),
      .o_mem_write  (mem_write),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_alu_op     (alu_op),
      .o_reg_write  (reg_write),
      .o_rd_addr    (rd_addr),
      .o_mem_to_reg (mem_to_reg),
      .o_halted     (halted),
      .o_illegal    (illegal),
      .o_state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word for a phase, straight from the per-phase rules.
   function automatic ctrl_t model(input phase_t ph, input logic [15:0] ins,
                                   input logic mr, input logic az);
      ctrl_t e;
      e = '0;
      if (ph == PH_RESET) return e;
      e.rd_addr = ins[11:9];
      case (ph)
         PH_FETCH: begin
            e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            e.ir_write = mr;   e.pc_write  = mr;
         end
         PH_DECODE:   e.alu_src_b = 2'b11;
         PH_EXEC_R: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = ins[2:0];
         end
         PH_EXEC_I, PH_MEM_ADDR: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
         end
         PH_MEM_RD:  begin e.mem_read = 1'b1;  e.iord = 1'b1; end
         PH_MEM_WR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
         PH_WB_ALU:  e.reg_write = (ins[11:9] != 3'd0);
         PH_WB_MEM: begin
            e.reg_write = (ins[11:9] != 3'd0); e.mem_to_reg = 1'b1;
         end
         PH_BRANCH: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b001;
            e.pc_src = 2'b01;   e.pc_write = az;
         end
         PH_JUMP:    begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
         PH_HALT:    e.halted  = 1'b1;
         PH_ILLEGAL: e.illegal = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   // Entered at posedge+1 with inputs already driven; compares at negedge,
   // returns at the following posedge+1.
   task automatic check_cycle(input phase_t ph, input string tag);
      ctrl_t e;
      e = model(ph, instr, mem_ready, alu_zero);
      @(negedge clk);
      n_asserts++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s [%s] t=%0t: got %h, expected %h",
                  tag, ph.name(), $time, act, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      n_asserts++;
      if (act !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h, expected 0", act);
      end
      rst = 1'b0;
      check_cycle(PH_RESET, "reset_release");
   endtask

   // Runs one instruction from FETCH; wf / wm = wait cycles in fetch / memory.
   task automatic run_instr(input logic [15:0] ins, input logic az,
                            input int wf, input int wm, input string tag);
      phase_t q[$];
      int     nw;
      instr    = ins;
      alu_zero = az;
      q.push_back(PH_FETCH);
      q.push_back(PH_DECODE);
      case (ins[15:12])
         4'h0: begin q.push_back(PH_EXEC_R); q.push_back(PH_WB_ALU); end
         4'h1: begin q.push_back(PH_EXEC_I); q.push_back(PH_WB_ALU); end
         4'h2: begin q.push_back(PH_MEM_ADDR); q.push_back(PH_MEM_RD);
                     q.push_back(PH_WB_MEM); end
         4'h3: begin q.push_back(PH_MEM_ADDR); q.push_back(PH_MEM_WR); end
         4'h4: q.push_back(PH_BRANCH);
         4'h5: q.push_back(PH_JUMP);
         4'hF: repeat (20) q.push_back(PH_HALT);
         default: repeat (20) q.push_back(PH_ILLEGAL);
      endcase
      foreach (q[i]) begin
         if (q[i] inside {PH_FETCH, PH_MEM_RD, PH_MEM_WR}) begin
            nw = (q[i] == PH_FETCH) ? wf : wm;
            for (int w = 0; w < nw; w++) begin
               mem_ready = 1'b0;
               check_cycle(q[i], tag);
            end
            mem_ready = 1'b1;
            check_cycle(q[i], tag);
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            check_cycle(q[i], tag);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      mem_ready = 1'b0;
      instr = 16'h0000;
      check_cycle(PH_FETCH, "reset_fetch");
   endtask

   task automatic test_reset_mid_memrd();
      do_reset();
      instr = 16'h2A05;
      mem_ready = 1'b1; check_cycle(PH_FETCH,    "rst_mid_fetch");
      mem_ready = 1'b0; check_cycle(PH_DECODE,   "rst_mid_decode");
      check_cycle(PH_MEM_ADDR, "rst_mid_addr");
      check_cycle(PH_MEM_RD,   "rst_mid_memrd");
      // Still in MEM_RD (no ready); assert reset between clock edges.
      #2;
      n_asserts++;
      if (act !== model(PH_MEM_RD, instr, 1'b0, alu_zero)) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got %h, expected MEM_RD word", act);
      end
      rst = 1'b1;
      #1;
      n_asserts++;
      if (act !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got %h, expected 0", act);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_cycle(PH_RESET, "rst_mid_release");
      check_cycle(PH_FETCH, "rst_mid_refetch");
   endtask

   task automatic test_rtype();
      do_reset();
      run_instr(16'h0601, 1'b0, 2, 0, "rtype_rd3");
   endtask

   task automatic test_load_store();
      run_instr(16'h2A05, 1'b0, 0, 3, "lw_rd5");
      run_instr(16'h3000, 1'b0, 1, 2, "sw");
      run_instr(16'h3000, 1'b1, 0, 0, "sw_nowait");
   endtask

   task automatic test_branch();
      run_instr(16'h4000, 1'b0, 0, 0, "beq_nz");
      run_instr(16'h4000, 1'b1, 0, 0, "beq_z");
   endtask

   task automatic test_rd0_jump();
      run_instr(16'h0001, 1'b0, 0, 0, "rtype_rd0");
      run_instr(16'h2005, 1'b0, 0, 1, "lw_rd0");
      run_instr(16'h5000, 1'b0, 0, 0, "jmp");
   endtask

   task automatic test_random();
      logic [15:0] ins;
      for (int n = 0; n < 60; n++) begin
         ins = 16'($urandom);
         ins[15:12] = 4'($urandom_range(0, 5));
         run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_illegal();
      run_instr(16'h7000, 1'b0, 0, 0, "illegal");
      do_reset();
      run_instr(16'hE123, 1'b0, 1, 0, "illegal_e");
   endtask

   task automatic test_halt();
      do_reset();
      run_instr(16'h0C07, 1'b0, 0, 0, "pre_halt");
      run_instr(16'hF000, 1'b0, 0, 0, "halt");
      do_reset();
      run_instr(16'h1E3F, 1'b0, 0, 0, "after_halt_addi");
   endtask

   initial begin
      rst       = 1'b1;
      instr     = 16'h0000;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      test_reset();
      test_reset_mid_memrd();
      test_rtype();
      test_load_store();
      test_branch();
      test_rd0_jump();
      test_random();
      test_illegal();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
